// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge data path.
// Contents:
//    state_t    - burst source FSM states (IDLE, SEND, DONE)
//    LFSR_W     - LFSR width in bits
//    LFSR_TAPS  - feedback tap mask (bits 7, 5, 4, 3)
//    lfsr_step  - one advance of the Fibonacci LFSR
package bridge_pkg;

   localparam int LFSR_W = 8;

   // The feedback bit is the XOR of lfsr[7], lfsr[5], lfsr[4] and lfsr[3].
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift left by one and insert the feedback bit at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with seed load on reset and an advance enable.
// Ports:
//    clka        - clock, rising edge
//    resetb_clkb - asynchronous active-high reset, loads SEED
//    advance     - step the LFSR once on this clock edge
//    value       - current LFSR state
module lfsr8
   import bridge_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
   input  logic              clka,
   input  logic              resetb_clkb,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] lfsr_reg;
   logic [LFSR_W-1:0] lfsr_next;

   always_comb begin
      lfsr_next = lfsr_reg;
      if (advance) begin
         lfsr_next = lfsr_step(lfsr_reg);
      end
   end

   always_ff @(posedge clka or posedge resetb_clkb) begin
      if (resetb_clkb) begin
         lfsr_reg <= SEED;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

   assign value = lfsr_reg;

endmodule

// File: rtl/burst_source.sv
// Burst data source for the bridge: on a rising edge of the request it emits
// BURST_LEN contiguous LFSR beats, then a one-cycle burst_done pulse.
// Ports:
//    clka            - clock, rising edge
//    resetb_clkb     - asynchronous active-high reset
//    data_req_clka   - burst request level; a 0->1 transition starts a burst
//    din_clka        - data beat (0 when no beat is valid)
//    data_valid_clka - din_clka carries a beat this cycle
//    busy            - burst in progress (SEND or DONE)
//    burst_done      - one-cycle pulse following the last beat
//    req_drop        - one-cycle pulse when a request edge arrives while busy
// All outputs come straight from flops.
module burst_source
   import bridge_pkg::*;
#(
   parameter int                BURST_LEN = 20,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
   input  logic              clka,
   input  logic              resetb_clkb,
   input  logic              data_req_clka,
   output logic [LFSR_W-1:0] din_clka,
   output logic              data_valid_clka,
   output logic              busy,
   output logic              burst_done,
   output logic              req_drop
);

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [7:0]        cnt_reg;
   logic [7:0]        cnt_next;
   logic              req_q_reg;
   logic              req_edge;

   logic [LFSR_W-1:0] din_reg;
   logic [LFSR_W-1:0] din_next;
   logic              valid_reg;
   logic              valid_next;
   logic              busy_reg;
   logic              busy_next;
   logic              done_reg;
   logic              done_next;
   logic              drop_reg;
   logic              drop_next;

   logic [LFSR_W-1:0] lfsr_value;
   logic              lfsr_advance;

   assign req_edge = data_req_clka & ~req_q_reg;

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clka        (clka),
      .resetb_clkb (resetb_clkb),
      .advance     (lfsr_advance),
      .value       (lfsr_value)
   );

   // Outputs are registered versions of what the next state implies, so the
   // state entered on an edge and the output flops agree in the same cycle.
   // Entering SEND from IDLE therefore presents beat 0 right after the edge
   // that sampled the request.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      lfsr_advance = 1'b0;
      valid_next   = 1'b0;
      din_next     = '0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      drop_next    = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (req_edge) begin
               state_next = SEND;
               cnt_next   = '0;
            end
         end
         SEND: begin
            // cnt_reg is the index of the beat currently on the output; it
            // stops at LAST_BEAT instead of wrapping.
            if (cnt_reg == LAST_BEAT) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A beat is loaded into din_reg on every edge that lands in SEND; the
      // LFSR steps on that same edge so the next beat is ready.
      if (state_next == SEND) begin
         lfsr_advance = 1'b1;
         valid_next   = 1'b1;
         din_next     = lfsr_value;
      end
      busy_next = (state_next != IDLE);
      done_next = (state_next == DONE);
      drop_next = req_edge && (state_reg != IDLE);
   end

   always_ff @(posedge clka or posedge resetb_clkb) begin
      if (resetb_clkb) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         req_q_reg <= 1'b0;
         din_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         drop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         req_q_reg <= data_req_clka;
         din_reg   <= din_next;
         valid_reg <= valid_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         drop_reg  <= drop_next;
      end
   end

   assign din_clka        = din_reg;
   assign data_valid_clka = valid_reg;
   assign busy            = busy_reg;
   assign burst_done      = done_reg;
   assign req_drop        = drop_reg;

endmodule

// File: tb/tb_burst_source.sv
// Directed testbench for burst_source: default-length instance (a) and a
// BURST_LEN=1 instance (b) sharing clock and reset.
module tb_burst_source;

   logic       clka = 1'b0;
   logic       resetb_clkb = 1'b1;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;

   logic [7:0] din_a;
   logic       valid_a;
   logic       busy_a;
   logic       done_a;
   logic       drop_a;
   logic [7:0] din_b;
   logic       valid_b;
   logic       busy_b;
   logic       done_b;
   logic       drop_b;

   int         n_checks = 0;
   int         n_errors = 0;

   // Monitor counters for instance a (written only by the monitor).
   int         beats = 0;
   int         dones = 0;
   int         drops = 0;
   int         busy_cyc = 0;
   logic [7:0] exp_lfsr = 8'hA5;

   // Snapshots taken by the main flow.
   int         beats0;
   int         dones0;
   int         drops0;
   int         busy0;
   logic [7:0] succ;

   burst_source #(.BURST_LEN(20), .LFSR_SEED(8'hA5)) dut_a (
      .clka            (clka),
      .resetb_clkb     (resetb_clkb),
      .data_req_clka   (req_a),
      .din_clka        (din_a),
      .data_valid_clka (valid_a),
      .busy            (busy_a),
      .burst_done      (done_a),
      .req_drop        (drop_a)
   );

   burst_source #(.BURST_LEN(1), .LFSR_SEED(8'hA5)) dut_b (
      .clka            (clka),
      .resetb_clkb     (resetb_clkb),
      .data_req_clka   (req_b),
      .din_clka        (din_b),
      .data_valid_clka (valid_b),
      .busy            (busy_b),
      .burst_done      (done_b),
      .req_drop        (drop_b)
   );

   always #5 clka = ~clka;

   function automatic logic [7:0] lfsr_step(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic snapshot();
      beats0 = beats;
      dones0 = dones;
      drops0 = drops;
      busy0  = busy_cyc;
   endtask

   // Sampled on the falling edge, midway between active edges.
   always @(negedge clka) begin
      if (resetb_clkb) begin
         exp_lfsr = 8'hA5;
      end else begin
         if (valid_a) begin
            check("din_seq", din_a, exp_lfsr);
            exp_lfsr = lfsr_step(exp_lfsr);
            beats++;
         end else begin
            check("din_idle_zero", din_a, 0);
         end
         if (done_a) dones++;
         if (drop_a) drops++;
         if (busy_a) busy_cyc++;
      end
   end

   initial begin
      // Reset state
      repeat (2) tick();
      check("rst_valid", valid_a, 0);
      check("rst_din", din_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_drop", drop_a, 0);
      resetb_clkb = 1'b0;
      repeat (2) tick();

      // BURST_LEN=1: single beat 0xA5 then burst_done
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      check("b_valid", valid_b, 1);
      check("b_din", din_b, 8'hA5);
      check("b_busy", busy_b, 1);
      tick();
      check("b_valid_end", valid_b, 0);
      check("b_done", done_b, 1);
      check("b_din_zero", din_b, 0);
      tick();
      check("b_done_end", done_b, 0);
      check("b_busy_end", busy_b, 0);
      $display("txn len1 burst: din=%0h", 8'hA5);

      // Single 1-cycle request -> 20 beats A5, 4A, 95, ...
      snapshot();
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      check("t1_beat0", din_a, 8'hA5);
      check("t1_valid0", valid_a, 1);
      tick();
      check("t1_beat1", din_a, 8'h4A);
      tick();
      check("t1_beat2", din_a, 8'h95);
      repeat (17) tick();
      check("t1_valid19", valid_a, 1);
      check("t1_nodone19", done_a, 0);
      tick();
      check("t1_done", done_a, 1);
      check("t1_valid_done", valid_a, 0);
      check("t1_busy_done", busy_a, 1);
      tick();
      check("t1_done_end", done_a, 0);
      check("t1_busy_end", busy_a, 0);
      repeat (2) tick();
      check("t1_beats", beats - beats0, 20);
      check("t1_dones", dones - dones0, 1);
      check("t1_busy_cyc", busy_cyc - busy0, 21);
      check("t1_drops", drops - drops0, 0);
      $display("txn single burst: beats=%0d dones=%0d busy=%0d", beats - beats0, dones - dones0, busy_cyc - busy0);

      // Second burst continues the LFSR sequence
      succ = 8'hA5;
      repeat (20) succ = lfsr_step(succ);
      snapshot();
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      check("t4_beat0", din_a, succ);
      repeat (25) tick();
      check("t4_beats", beats - beats0, 20);
      check("t4_dones", dones - dones0, 1);
      $display("txn second burst: first beat=%0h", din_a);

      // Request held high for 100 cycles -> one burst, no drops
      snapshot();
      req_a = 1'b1;
      repeat (100) tick();
      req_a = 1'b0;
      repeat (3) tick();
      check("t2_beats", beats - beats0, 20);
      check("t2_dones", dones - dones0, 1);
      check("t2_drops", drops - drops0, 0);
      $display("txn held request: beats=%0d drops=%0d", beats - beats0, drops - drops0);

      // Second pulse mid-burst -> one req_drop, burst unaffected
      snapshot();
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      repeat (5) tick();
      req_a = 1'b1;
      tick();
      check("t3_drop_pulse", drop_a, 1);
      req_a = 1'b0;
      tick();
      check("t3_drop_end", drop_a, 0);
      repeat (25) tick();
      check("t3_beats", beats - beats0, 20);
      check("t3_dones", dones - dones0, 1);
      check("t3_drops", drops - drops0, 1);
      $display("txn mid-burst request: drops=%0d", drops - drops0);

      // Reset at beat 10 -> immediate zero outputs, no burst_done
      snapshot();
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      repeat (10) tick();
      check("t5_valid10", valid_a, 1);
      #2;
      resetb_clkb = 1'b1;
      #1;
      check("t5_rst_valid", valid_a, 0);
      check("t5_rst_din", din_a, 0);
      check("t5_rst_busy", busy_a, 0);
      check("t5_rst_done", done_a, 0);
      tick();
      resetb_clkb = 1'b0;
      repeat (25) tick();
      check("t5_beats", beats - beats0, 10);
      check("t5_dones", dones - dones0, 0);
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      check("t5_restart", din_a, 8'hA5);
      repeat (25) tick();
      $display("txn reset mid-burst: beats=%0d dones=%0d", beats - beats0, dones - dones0);

      // Request already high at reset release counts as an edge
      resetb_clkb = 1'b1;
      req_a = 1'b1;
      tick();
      check("t6_rst_valid", valid_a, 0);
      resetb_clkb = 1'b0;
      tick();
      check("t6_valid", valid_a, 1);
      check("t6_din", din_a, 8'hA5);
      req_a = 1'b0;
      repeat (25) tick();
      $display("txn request high through reset: started burst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/burst_source.md
BURST_SOURCE -- requirements
Module: burst_source

Interface
REQ-001 SHALL provide parameter BURST_LEN, default 20: beats per burst; legal range 1..255.
REQ-002 SHALL provide parameter LFSR_SEED, default 8'hA5: LFSR reset value; must be nonzero.
REQ-003 SHALL have port clka, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port resetb_clkb, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port data_req_clka, input, 1 bit: burst request, clka-synchronous, from the bridge request path.
REQ-006 SHALL have port din_clka, output, 8 bits: burst data beat toward the bridge.
REQ-007 SHALL have port data_valid_clka, output, 1 bit: din_clka carries a valid beat this cycle.
REQ-008 SHALL have port busy, output, 1 bit: high while in SEND or DONE.
REQ-009 SHALL have port burst_done, output, 1 bit: one-cycle pulse after the last beat of a burst.
REQ-010 SHALL have port req_drop, output, 1 bit: one-cycle pulse when a request edge is ignored.

Function
REQ-011 SHALL drive all outputs directly from flops; no combinational input-to-output path.
REQ-012 SHALL detect a request as data_req_clka==1 while its registered copy req_q==0; a held-high level SHALL NOT retrigger.
REQ-013 SHALL implement FSM states IDLE, SEND, DONE.
REQ-014 IDLE: on a request edge, go to SEND and clear the beat counter; otherwise stay.
REQ-015 SEND: data_valid_clka=1, din_clka=current LFSR value; LFSR advances and counter increments each cycle.
REQ-016 SEND: the cycle carrying beat BURST_LEN-1 SHALL be followed by DONE.
REQ-017 DONE: burst_done=1, data_valid_clka=0 for exactly one cycle, then go to IDLE.
REQ-018 Latency: the request edge is sampled at clka edge k; beat 0 SHALL be valid at edge k+1; beats SHALL be contiguous with no gaps.
REQ-019 LFSR next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; it advances only on valid beats.
REQ-020 The LFSR SHALL persist across bursts and SHALL NOT be reseeded except by reset.
REQ-021 din_clka SHALL be 8'h00 whenever data_valid_clka=0.
REQ-022 A request edge in SEND or DONE SHALL be ignored and SHALL pulse req_drop for one cycle; the current burst continues unaffected.
REQ-023 The beat counter SHALL be 8 bits and SHALL never wrap within a burst.

Reset
REQ-024 Asserting resetb_clkb SHALL immediately force state=IDLE, counter=0, req_q=0, lfsr=LFSR_SEED, and all outputs to 0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no burst_done pulse.
REQ-026 After release, data_req_clka already high SHALL count as an edge, because req_q resets to 0.

Structure
REQ-027 SHALL place the state enum (IDLE/SEND/DONE), the LFSR width and the tap constants in shared package bridge_pkg.
REQ-028 SHALL use one sub-module, lfsr8, containing the seed-load and advance-enable logic.

Verification
REQ-029 Reset, then one 1-cycle request -> exactly 20 valid beats starting 0xA5, 0x4A, 0x95; burst_done one cycle after beat 19; busy high for 21 cycles.
REQ-030 Request held high for 100 cycles -> exactly one burst, req_drop never asserted.
REQ-031 Second request pulse at beat 5 -> req_drop pulses once; 20 beats total; no second burst.
REQ-032 Two bursts separated by IDLE -> beat 0 of burst 2 equals the successor of beat 19 of burst 1.
REQ-033 Reset asserted at beat 10 -> outputs 0 immediately, no burst_done; the next request restarts at 0xA5.
REQ-034 BURST_LEN=1 -> a single valid beat 0xA5, then burst_done on the next cycle.
